// File: rtl/vortex_dcr_receiver.sv
// -----------------------------------------------------------------------------
// vortex_dcr_receiver
//
// Purpose:
//   Vortex-side receiving end of the Piton DCR write path. DCR write messages
//   (address/data) arrive over a valid/ready handshake and are queued in a
//   small FIFO. While the run controller is idle, queued entries are replayed
//   onto the Vortex DCR write bus as single-cycle strobes. A write with data
//   bit 0 set to the control address launches a kernel: Vortex reset is held
//   for RESET_CYCLES cycles, then released, and vx_busy is tracked until the
//   kernel completes.
//
// Ports:
//   clk              in   clock
//   rst              in   asynchronous, active-high reset
//   in_valid         in   DCR message valid (from the Piton DCR buffer)
//   in_addr          in   message address
//   in_data          in   message data
//   in_rdy           out  FIFO can accept a message
//   vx_dcr_wr_valid  out  Vortex DCR write strobe (one cycle per write)
//   vx_dcr_wr_addr   out  Vortex DCR address (holds after the strobe)
//   vx_dcr_wr_data   out  Vortex DCR data (holds after the strobe)
//   vx_reset         out  Vortex reset
//   vx_busy          in   Vortex busy
//   run_active       out  high while waiting for / tracking a kernel run
//   run_done         out  one-cycle pulse when a run completes
//   err_addr         out  sticky: a message was dropped as out of range
// -----------------------------------------------------------------------------
module vortex_dcr_receiver #(
  parameter int VX_DCR_ADDR_WIDTH = 8,
  parameter int VX_DCR_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH        = 4,
  parameter logic [VX_DCR_ADDR_WIDTH-1:0] DCR_BASE_ADDR = 8'h01,
  parameter logic [VX_DCR_ADDR_WIDTH-1:0] DCR_END_ADDR  = 8'hFE,
  parameter logic [VX_DCR_ADDR_WIDTH-1:0] CTRL_ADDR     = 8'hFF,
  parameter int RESET_CYCLES      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [VX_DCR_ADDR_WIDTH-1:0] in_addr,
  input  logic [VX_DCR_DATA_WIDTH-1:0] in_data,
  output logic                         in_rdy,
  output logic                         vx_dcr_wr_valid,
  output logic [VX_DCR_ADDR_WIDTH-1:0] vx_dcr_wr_addr,
  output logic [VX_DCR_DATA_WIDTH-1:0] vx_dcr_wr_data,
  output logic                         vx_reset,
  input  logic                         vx_busy,
  output logic                         run_active,
  output logic                         run_done,
  output logic                         err_addr
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [PW:0]   PTR_ONE  = (PW+1)'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET,
    S_WAIT_BUSY,
    S_RUN
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  logic [VX_DCR_ADDR_WIDTH-1:0] r_addr_mem [FIFO_DEPTH];
  logic [VX_DCR_DATA_WIDTH-1:0] r_data_mem [FIFO_DEPTH];

  // One extra MSB on each pointer separates "full" from "empty" when the
  // index bits are equal after wrap-around.
  logic [PW:0] r_wr_ptr;
  logic [PW:0] r_rd_ptr;

  logic                         w_empty;
  logic                         w_full;
  logic                         w_push;
  logic                         w_pop;
  logic [VX_DCR_ADDR_WIDTH-1:0] w_head_addr;
  logic [VX_DCR_DATA_WIDTH-1:0] w_head_data;
  logic                         w_head_is_ctrl;
  logic                         w_head_in_range;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

  // Ready depends only on the registered pointers: a pop in the same cycle
  // does not open a slot, which keeps in_rdy free of any path from the FSM.
  assign in_rdy = ~rst & ~w_full;
  assign w_push = in_valid & in_rdy;

  assign w_head_addr     = r_addr_mem[r_rd_ptr[PW-1:0]];
  assign w_head_data     = r_data_mem[r_rd_ptr[PW-1:0]];
  assign w_head_is_ctrl  = (w_head_addr == CTRL_ADDR);
  assign w_head_in_range = (w_head_addr >= DCR_BASE_ADDR) &&
                           (w_head_addr <= DCR_END_ADDR);

  // Storage is not reset: the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_mem[r_wr_ptr[PW-1:0]] <= in_addr;
      r_data_mem[r_wr_ptr[PW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Run-control FSM
  // ---------------------------------------------------------------------------
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_fwd;
  logic          w_bad;
  logic          w_done_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    w_fwd       = 1'b0;
    w_bad       = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_empty) begin
          w_pop = 1'b1;
          // The control address takes priority over the range check so a
          // range that happens to include it never forwards a launch word.
          if (w_head_is_ctrl) begin
            if (w_head_data[0]) w_state_nxt = S_RESET;
          end else if (w_head_in_range) begin
            w_fwd = 1'b1;
          end else begin
            w_bad = 1'b1;
          end
        end
      end
      S_RESET: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_WAIT_BUSY;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_WAIT_BUSY: begin
        if (vx_busy) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!vx_busy) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counter and all registered outputs. vx_reset and run_active are
  // taken from the next state so they move on the same edge as the state.
  logic                         r_vx_reset;
  logic                         r_run_active;
  logic                         r_run_done;
  logic                         r_wr_valid;
  logic [VX_DCR_ADDR_WIDTH-1:0] r_wr_addr;
  logic [VX_DCR_DATA_WIDTH-1:0] r_wr_data;
  logic                         r_err_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_vx_reset   <= 1'b1;
      r_run_active <= 1'b0;
      r_run_done   <= 1'b0;
      r_wr_valid   <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_err_addr   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_vx_reset   <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_RESET);
      r_run_active <= (w_state_nxt == S_WAIT_BUSY) || (w_state_nxt == S_RUN);
      r_run_done   <= w_done_nxt;
      r_wr_valid   <= w_fwd;
      if (w_fwd) begin
        r_wr_addr <= w_head_addr;
        r_wr_data <= w_head_data;
      end
      if (w_bad) r_err_addr <= 1'b1;
    end
  end

  assign vx_dcr_wr_valid = r_wr_valid;
  assign vx_dcr_wr_addr  = r_wr_addr;
  assign vx_dcr_wr_data  = r_wr_data;
  assign vx_reset        = r_vx_reset;
  assign run_active      = r_run_active;
  assign run_done        = r_run_done;
  assign err_addr        = r_err_addr;

endmodule
